// File: rtl/case_4_mul_pipe_hs.sv
// case_4_mul_pipe_hs: NUM_STAGE-deep valid/ready multiplier pipeline; define CASE_4_MUL_SAT_EN to saturate dout on overflow instead of wrapping.
module case_4_mul_pipe_hs #(
    parameter int ID         = 1,
    parameter int NUM_STAGE  = 3,
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 6,
    parameter int dout_WIDTH = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  signed_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int PW = din0_WIDTH + din1_WIDTH + 1;
    localparam int DW = dout_WIDTH;

    logic                 w_adv;
    logic [NUM_STAGE-1:0] r_vld;
    logic [NUM_STAGE-1:0] w_vnext;
    logic [PW-1:0]        w_a;
    logic [PW-1:0]        w_b;
    logic [PW-1:0]        w_prod;
    logic [PW-1:0]        w_lp;
    logic                 w_ls;
    logic signed [PW-1:0] w_sh;
    logic [DW-1:0]        w_dout;
    logic [DW-1:0]        r_dout;
    logic                 w_ovf;
    logic                 r_ovf;

    assign out_valid = r_vld[NUM_STAGE-1];
    assign dout      = r_dout;
    assign ovf       = r_ovf;
    assign w_adv     = ce & (~out_valid | out_ready);
    assign in_ready  = w_adv & ~reset;

    // Extending both operands to the full product width makes one PW-bit multiply exact for either mode.
    assign w_a    = signed_mode ? PW'($signed(din0)) : PW'(din0);
    assign w_b    = signed_mode ? PW'($signed(din1)) : PW'(din1);
    assign w_prod = w_a * w_b;

    generate
        if (NUM_STAGE == 1) begin : g_one
            assign w_lp    = w_prod;
            assign w_ls    = signed_mode;
            assign w_vnext = in_valid;
        end else begin : g_chain
            logic [PW-1:0]        r_prod [NUM_STAGE-1];
            logic [NUM_STAGE-2:0] r_sm;
            // Product and mode travel down the inner stages; the last stage holds only the formatted result.
            always_ff @(posedge clk) begin
                if (w_adv) begin
                    r_prod[0] <= w_prod;
                    r_sm[0]   <= signed_mode;
                    for (int k = 1; k < NUM_STAGE - 1; k++) begin
                        r_prod[k] <= r_prod[k-1];
                        r_sm[k]   <= r_sm[k-1];
                    end
                end
            end
            assign w_lp    = r_prod[NUM_STAGE-2];
            assign w_ls    = r_sm[NUM_STAGE-2];
            assign w_vnext = {r_vld[NUM_STAGE-2:0], in_valid};
        end
    endgenerate

    // Signed fit: all bits from DW-1 upward equal; unsigned fit: nothing at or above bit DW.
    assign w_sh  = $signed(w_lp) >>> (DW - 1);
    assign w_ovf = w_ls ? ((w_sh != '0) && (w_sh != '1)) : ((w_lp >> DW) != '0);

`ifdef CASE_4_MUL_SAT_EN
    logic [DW-1:0] w_smax;
    assign w_smax = {DW{1'b1}} >> 1;
    assign w_dout = !w_ovf ? w_lp[DW-1:0] : !w_ls ? {DW{1'b1}} : w_lp[PW-1] ? ~w_smax : w_smax;
`else
    assign w_dout = w_lp[DW-1:0];
`endif

    // Valid bits and the output register shift together; reset wins over ce.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_vld  <= '0;
            r_dout <= '0;
            r_ovf  <= 1'b0;
        end else if (w_adv) begin
            r_vld  <= w_vnext;
            r_dout <= w_dout;
            r_ovf  <= w_ovf;
        end
    end
endmodule
